// File: rtl/sim_exit_pkg.sv
// Shared types and constants for the simulation-exit controller.
package sim_exit_pkg;

    // Controller life cycle: sampling, flushing output traffic, finished.
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } sim_exit_state_t;

    // Code reported when the inactivity watchdog fires.
    localparam logic [31:0] TIMEOUT_CODE_DFLT = 32'hDEAD_0001;

    // Width of the source index; one extra value encodes "watchdog".
    function automatic int unsigned src_w(input int unsigned n_src);
        return $clog2(n_src + 1);
    endfunction

endpackage

// File: rtl/sim_exit_prio_enc.sv
// Lowest-index-nonzero priority encoder over the packed exit-code bus.
module sim_exit_prio_enc
    import sim_exit_pkg::*;
#(
    parameter int unsigned N_SRC  = 2,
    parameter int unsigned CODE_W = 32,
    localparam int unsigned SRC_W = src_w(N_SRC)
) (
    input  logic [N_SRC*CODE_W-1:0] codes_i,
    output logic                    any_o,
    output logic [SRC_W-1:0]        idx_o,
    output logic [CODE_W-1:0]       code_o
);

    // Scan from the top down so the lowest nonzero source is written last and wins.
    always_comb begin
        // NOTE: every output gets a default before the loop; otherwise a path
        // with no nonzero source would leave it unassigned and infer a latch.
        any_o  = 1'b0;
        idx_o  = '0;
        code_o = '0;
        for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
            if (codes_i[i*CODE_W +: CODE_W] != '0) begin
                any_o  = 1'b1;
                idx_o  = SRC_W'(i);
                code_o = codes_i[i*CODE_W +: CODE_W];
            end
        end
    end

endmodule

// File: rtl/sim_exit_ctrl.sv
// Simulation-exit controller: latches the first exit request (source or
// watchdog), waits a drain delay so output traffic can flush, then raises a
// sticky done flag for the sim top to act on.
module sim_exit_ctrl
    import sim_exit_pkg::*;
#(
    parameter int unsigned N_SRC          = 2,
    parameter int unsigned CODE_W         = 32,
    parameter int unsigned DRAIN_CYCLES   = 16,
    parameter int unsigned TIMEOUT_CYCLES = 0,
    parameter int unsigned CNT_W          = 32,
    parameter logic [31:0] TIMEOUT_CODE   = TIMEOUT_CODE_DFLT,
    localparam int unsigned SRC_W         = src_w(N_SRC)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    enable_i,
    input  logic [N_SRC*CODE_W-1:0] src_code_i,
    input  logic                    kick_i,
    output logic [CODE_W-1:0]       exit_code_o,
    output logic [SRC_W-1:0]        exit_src_o,
    output logic                    timeout_o,
    output logic                    draining_o,
    output logic                    done_o
);

    localparam logic [CODE_W-1:0] TO_CODE    = CODE_W'(TIMEOUT_CODE);
    localparam logic [CNT_W-1:0]  DRAIN_LOAD = CNT_W'(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0]  WD_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [SRC_W-1:0]  WD_SRC     = SRC_W'(N_SRC);
    localparam bit                WD_EN      = (TIMEOUT_CYCLES != 0);

    sim_exit_state_t    state_q, state_d;
    logic [CNT_W-1:0]   wdog_q, wdog_d;
    logic [CNT_W-1:0]   drain_q, drain_d;
    logic [CODE_W-1:0]  code_q, code_d;
    logic [SRC_W-1:0]   src_q, src_d;
    logic               to_q, to_d;

    logic               enc_any;
    logic [SRC_W-1:0]   enc_idx;
    logic [CODE_W-1:0]  enc_code;

    sim_exit_prio_enc #(
        .N_SRC  (N_SRC),
        .CODE_W (CODE_W)
    ) u_prio_enc (
        .codes_i (src_code_i),
        .any_o   (enc_any),
        .idx_o   (enc_idx),
        .code_o  (enc_code)
    );

    // Next-state logic: source sampling and watchdog in RUN, countdown in DRAIN.
    always_comb begin
        state_d = state_q;
        wdog_d  = wdog_q;
        drain_d = drain_q;
        code_d  = code_q;
        src_d   = src_q;
        to_d    = to_q;
        unique case (state_q)
            ST_RUN: begin
                if (!enable_i) begin
                    wdog_d = '0;
                end else if (enc_any) begin
                    // A source request beats a watchdog expiry on the same edge.
                    code_d  = enc_code;
                    src_d   = enc_idx;
                    drain_d = DRAIN_LOAD;
                    wdog_d  = '0;
                    state_d = ST_DRAIN;
                end else if (WD_EN) begin
                    if (kick_i) begin
                        wdog_d = '0;
                    end else if (wdog_q == WD_LAST) begin
                        code_d  = TO_CODE;
                        src_d   = WD_SRC;
                        to_d    = 1'b1;
                        drain_d = DRAIN_LOAD;
                        wdog_d  = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        wdog_d = wdog_q + CNT_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_q == '0) state_d = ST_DONE;
                else               drain_d = drain_q - CNT_W'(1);
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // State and latched-exit registers; reset clears any pending exit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_RUN;
            wdog_q  <= '0;
            drain_q <= '0;
            code_q  <= '0;
            src_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed above, independent of statement order.
            state_q <= state_d;
            wdog_q  <= wdog_d;
            drain_q <= drain_d;
            code_q  <= code_d;
            src_q   <= src_d;
            to_q    <= to_d;
        end
    end

    assign exit_code_o = code_q;
    assign exit_src_o  = src_q;
    assign timeout_o   = to_q;
    assign draining_o  = (state_q == ST_DRAIN);
    assign done_o      = (state_q == ST_DONE);

endmodule

// File: tb/tb_sim_exit_ctrl.sv
// Directed bench for sim_exit_ctrl. Three instances share inputs:
//   u0: DRAIN=4,  watchdog off
//   u1: DRAIN=0,  TIMEOUT=100
//   u2: DRAIN=4,  TIMEOUT=50
// Expected exits are queued when stimulus is driven and compared when the
// chosen instance starts draining.
module tb_sim_exit_ctrl;

    localparam logic [31:0] TO_CODE = 32'hDEAD_0001;

    typedef struct {
        int          inst;
        int          edge_n;
        logic [31:0] code;
        logic [1:0]  src;
        logic        to;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        kick;
    logic [63:0] src;

    logic [2:0][31:0] code_o;
    logic [2:0][1:0]  src_o;
    logic [2:0]       to_o;
    logic [2:0]       dr_o;
    logic [2:0]       dn_o;

    exp_t exp_q[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    sim_exit_ctrl #(.N_SRC(2), .CODE_W(32), .DRAIN_CYCLES(4), .TIMEOUT_CYCLES(0)) u0 (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .src_code_i(src), .kick_i(kick),
        .exit_code_o(code_o[0]), .exit_src_o(src_o[0]), .timeout_o(to_o[0]),
        .draining_o(dr_o[0]), .done_o(dn_o[0]));

    sim_exit_ctrl #(.N_SRC(2), .CODE_W(32), .DRAIN_CYCLES(0), .TIMEOUT_CYCLES(100)) u1 (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .src_code_i(src), .kick_i(kick),
        .exit_code_o(code_o[1]), .exit_src_o(src_o[1]), .timeout_o(to_o[1]),
        .draining_o(dr_o[1]), .done_o(dn_o[1]));

    sim_exit_ctrl #(.N_SRC(2), .CODE_W(32), .DRAIN_CYCLES(4), .TIMEOUT_CYCLES(50)) u2 (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .src_code_i(src), .kick_i(kick),
        .exit_code_o(code_o[2]), .exit_src_o(src_o[2]), .timeout_o(to_o[2]),
        .draining_o(dr_o[2]), .done_o(dn_o[2]));

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and sample 1 ns later; cyc is the edge number.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int k);
        while (cyc < k) tick();
    endtask

    // Hold reset over two edges, release at a negedge so the next posedge is edge 1.
    task automatic reset_all();
        rst_n = 1'b0;
        en    = 1'b0;
        kick  = 1'b0;
        src   = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic push(input int inst, input int edge_n, input logic [31:0] code,
                        input logic [1:0] s, input logic to);
        exp_t e;
        e.inst = inst; e.edge_n = edge_n; e.code = code; e.src = s; e.to = to;
        exp_q.push_back(e);
    endtask

    // Pop the next expected exit and wait (bounded) for that instance to drain.
    task automatic wait_exit(input string tag, input int budget);
        exp_t e;
        bit   seen;
        e    = exp_q.pop_front();
        seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            tick();
            if (dr_o[e.inst]) seen = 1'b1;
        end
        check({tag, "_seen"}, 128'(seen), 128'(1));
        if (seen) begin
            check({tag, "_edge"}, 128'(cyc), 128'(e.edge_n));
            check({tag, "_code"}, 128'(code_o[e.inst]), 128'(e.code));
            check({tag, "_src"},  128'(src_o[e.inst]), 128'(e.src));
            check({tag, "_to"},   128'(to_o[e.inst]), 128'(e.to));
            check({tag, "_done"}, 128'(dn_o[e.inst]), 128'(0));
        end
    endtask

    initial begin
        // Reset state of every instance.
        reset_all();
        check("rst_code",  128'(code_o), 128'(0));
        check("rst_src",   128'(src_o), 128'(0));
        check("rst_to",    128'(to_o), 128'(0));
        check("rst_drain", 128'(dr_o), 128'(0));
        check("rst_done",  128'(dn_o), 128'(0));

        // Source 1 at edge 10, drain 4: draining edges 10..14, done after 15.
        en = 1'b1;
        run_to(9);
        src[63:32] = 32'h55;
        push(0, 10, 32'h55, 2'd1, 1'b0);
        wait_exit("src1", 20);
        run_to(14);
        check("drain_e14", 128'(dr_o[0]), 128'(1));
        check("done_e14",  128'(dn_o[0]), 128'(0));
        tick();
        check("done_e15",  128'(dn_o[0]), 128'(1));
        check("drain_e15", 128'(dr_o[0]), 128'(0));
        repeat (5) tick();
        check("done_hold", 128'(dn_o[0]), 128'(1));
        check("code_hold", 128'(code_o[0]), 128'(32'h55));

        // Simultaneous sources: lowest index wins, later changes ignored.
        reset_all();
        en = 1'b1;
        run_to(2);
        src = {32'h7, 32'h3};
        push(0, 3, 32'h3, 2'd0, 1'b0);
        wait_exit("prio", 10);
        src = {32'hAA, 32'h0};
        run_to(5);
        check("prio_code_frozen", 128'(code_o[0]), 128'(32'h3));
        check("prio_src_frozen",  128'(src_o[0]), 128'(0));
        check("prio_mid_drain",   128'(dr_o[0]), 128'(1));

        // Asynchronous reset mid-drain clears outputs without a clock edge.
        rst_n = 1'b0;
        #1;
        check("arst_code",  128'(code_o[0]), 128'(0));
        check("arst_src",   128'(src_o[0]), 128'(0));
        check("arst_drain", 128'(dr_o[0]), 128'(0));
        check("arst_done",  128'(dn_o[0]), 128'(0));
        reset_all();
        en = 1'b1;
        src[63:32] = 32'h11;
        push(0, 1, 32'h11, 2'd1, 1'b0);
        wait_exit("post_rst", 5);

        // Watchdog 100, kick at edge 50: expiry at edge 150, done after 151.
        reset_all();
        en = 1'b1;
        run_to(49);
        kick = 1'b1;
        tick();
        kick = 1'b0;
        push(1, 150, TO_CODE, 2'd2, 1'b1);
        wait_exit("wdog", 150);
        tick();
        check("wdog_done",  128'(dn_o[1]), 128'(1));
        check("wdog_drain", 128'(dr_o[1]), 128'(0));

        // Source on the expiry edge beats the watchdog.
        reset_all();
        en = 1'b1;
        run_to(99);
        src[31:0] = 32'h9;
        push(1, 100, 32'h9, 2'd0, 1'b0);
        wait_exit("src_vs_wdog", 5);
        tick();
        check("d0_done", 128'(dn_o[1]), 128'(1));

        // Disabled: source ignored and watchdog held for 200 edges.
        reset_all();
        src[31:0] = 32'h1;
        run_to(200);
        check("dis_drain", 128'(dr_o[2]), 128'(0));
        check("dis_done",  128'(dn_o[2]), 128'(0));
        check("dis_code",  128'(code_o[2]), 128'(0));
        en = 1'b1;
        push(2, 201, 32'h1, 2'd0, 1'b0);
        wait_exit("enable", 5);

        // Watchdog counts only from enable: 200 disabled edges, then 50 enabled.
        reset_all();
        run_to(200);
        en = 1'b1;
        push(2, 250, TO_CODE, 2'd2, 1'b1);
        wait_exit("wdog_hold", 80);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
